reg_context_engine: RTL and testbench

- Initiator-side sequencer for the 16x32 register bank.
- Drives the bank's read ports (RA/RB → PRA/PRB) and write port (WC/WPC/W_RB).
- SAVE: dumps all registers to word-addressed memory. RESTORE: reloads them from memory.
- Used for context switch and debug dump; sits between the control unit and the data-memory arbiter.

---
 rtl/reg_context_engine.sv | 170 +++++++++++++++++
 tb/tb_reg_context_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_context_engine.sv
// ============================================================================
// Module   : reg_context_engine
// Function : Register-bank SAVE/RESTORE sequencer between bank and memory.
//            Optional CHECKSUM output when REG_CTX_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_context_engine #(
    parameter int NREGS      = 16,
    parameter int WORD_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        SAVE,
    input  logic [31:0] BASE_ADDR,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  RA,
    output logic [3:0]  RB,
    input  logic [31:0] PRA,
    input  logic [31:0] PRB,
    output logic [3:0]  WC,
    output logic [31:0] WPC,
    output logic        W_RB,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic        MEM_WE,
    output logic        MEM_RE,
`ifdef REG_CTX_CHECKSUM_EN
    output logic [31:0] CHECKSUM,
`endif
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_READY
);

    localparam logic [4:0]  C_NREGS = 5'(NREGS);
    localparam logic [4:0]  C_LAST  = 5'(NREGS - 1);
    localparam logic [31:0] C_STEP  = 32'(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SV_A  = 3'd1,
        SV_B  = 3'd2,
        RS_RD = 3'd3,
        RS_WR = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [3:0]  wc_q, wc_d;
    logic [31:0] wpc_q, wpc_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            wc_q    <= '0;
            wpc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            wc_q    <= wc_d;
            wpc_q   <= wpc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        wc_d    = wc_q;
        wpc_d   = wpc_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    addr_d  = BASE_ADDR;
                    idx_d   = '0;
                    ra_d    = 4'd0;
                    rb_d    = 4'd1;
                    state_d = SAVE ? SV_A : RS_RD;
                end
            end
            SV_A: begin
                if (MEM_READY) begin
                    addr_d  = addr_q + C_STEP;
                    state_d = SV_B;
                end
            end
            SV_B: begin
                // Read addresses advance as a pair only after both words land.
                if (MEM_READY) begin
                    addr_d  = addr_q + C_STEP;
                    idx_d   = idx_q + 5'd2;
                    ra_d    = ra_q + 4'd2;
                    rb_d    = rb_q + 4'd2;
                    state_d = (idx_q + 5'd2 == C_NREGS) ? FIN : SV_A;
                end
            end
            RS_RD: begin
                if (MEM_READY) begin
                    wpc_d   = MEM_RDATA;
                    wc_d    = idx_q[3:0];
                    addr_d  = addr_q + C_STEP;
                    state_d = RS_WR;
                end
            end
            RS_WR: begin
                idx_d   = idx_q + 5'd1;
                state_d = (idx_q == C_LAST) ? FIN : RS_RD;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state so a synchronous reset clears them at once.
    assign BUSY      = (state_q == SV_A) || (state_q == SV_B) ||
                       (state_q == RS_RD) || (state_q == RS_WR);
    assign DONE      = (state_q == FIN);
    assign MEM_WE    = (state_q == SV_A) || (state_q == SV_B);
    assign MEM_RE    = (state_q == RS_RD);
    assign W_RB      = (state_q == RS_WR);
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = (state_q == SV_A) ? PRA :
                       (state_q == SV_B) ? PRB : 32'd0;
    assign RA        = ra_q;
    assign RB        = rb_q;
    assign WC        = wc_q;
    assign WPC       = wpc_q;

`ifdef REG_CTX_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == IDLE) && START) begin
            checksum_d = '0;
        end else if ((MEM_WE || MEM_RE) && MEM_READY) begin
            checksum_d = checksum_q ^ (MEM_WE ? MEM_WDATA : MEM_RDATA);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign CHECKSUM = checksum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_context_engine.sv
// ============================================================================
// Module   : tb_reg_context_engine
// Function : Self-checking bench for reg_context_engine with bank/memory models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_context_engine;

    localparam int NR = 16;

    logic        CLK = 1'b0;
    logic        RESET, START, SAVE;
    logic [31:0] BASE_ADDR;
    logic        BUSY, DONE, W_RB, MEM_WE, MEM_RE, MEM_READY;
    logic [3:0]  RA, RB, WC;
    logic [31:0] PRA, PRB, WPC, MEM_ADDR, MEM_WDATA, MEM_RDATA;
`ifdef REG_CTX_CHECKSUM_EN
    logic [31:0] CHECKSUM;
`endif

    always #5 CLK = ~CLK;

    reg_context_engine #(.NREGS(NR), .WORD_BYTES(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SAVE(SAVE),
        .BASE_ADDR(BASE_ADDR), .BUSY(BUSY), .DONE(DONE),
        .RA(RA), .RB(RB), .PRA(PRA), .PRB(PRB),
        .WC(WC), .WPC(WPC), .W_RB(W_RB),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_WE(MEM_WE), .MEM_RE(MEM_RE),
`ifdef REG_CTX_CHECKSUM_EN
        .CHECKSUM(CHECKSUM),
`endif
        .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY)
    );

    // Environment: register bank, word memory and a programmable-wait responder.
    logic [31:0] bank [NR];
    logic [31:0] mem [256];
    logic [31:0] bank_init [NR];
    logic [31:0] mem_init [256];
    logic [31:0] exp_bank [NR];
    logic        load_env, clr_mon;
    int          wait_cfg;
    int          wcnt;

    assign PRA       = bank[RA];
    assign PRB       = bank[RB];
    assign MEM_RDATA = mem[MEM_ADDR[9:2]];
    assign MEM_READY = (MEM_WE || MEM_RE) && (wcnt >= wait_cfg);

    int          wr_cnt, wrb_cnt, wrb_long, done_cnt, excl_viol, stall_viol;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    logic        prev_stall, prev_wrb;
    logic [31:0] stall_addr, stall_data;

    always @(posedge CLK) begin
        if (load_env) begin
            for (int i = 0; i < NR; i++) bank[i] <= bank_init[i];
            for (int i = 0; i < 256; i++) mem[i] <= mem_init[i];
        end else begin
            if (W_RB) bank[WC] <= WPC;
            if (MEM_WE && MEM_READY) mem[MEM_ADDR[9:2]] <= MEM_WDATA;
        end
        if ((MEM_WE || MEM_RE) && !MEM_READY) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (clr_mon) begin
            wr_cnt <= 0; wrb_cnt <= 0; wrb_long <= 0;
            done_cnt <= 0; excl_viol <= 0; stall_viol <= 0;
        end else begin
            if (MEM_WE && MEM_READY) begin
                log_addr[wr_cnt[5:0]] <= MEM_ADDR;
                log_data[wr_cnt[5:0]] <= MEM_WDATA;
                wr_cnt <= wr_cnt + 1;
            end
            if (W_RB) wrb_cnt <= wrb_cnt + 1;
            if (W_RB && prev_wrb) wrb_long <= wrb_long + 1;
            if (DONE) done_cnt <= done_cnt + 1;
            if (int'(MEM_WE) + int'(MEM_RE) + int'(W_RB) > 1) excl_viol <= excl_viol + 1;
            if (prev_stall && (MEM_ADDR !== stall_addr || MEM_WDATA !== stall_data))
                stall_viol <= stall_viol + 1;
        end
        prev_stall <= (MEM_WE || MEM_RE) && !MEM_READY;
        stall_addr <= MEM_ADDR;
        stall_data <= MEM_WDATA;
        prev_wrb   <= W_RB;
    end

    int n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  {31'd0, BUSY},   32'd0);
        check({tag, "_done"},  {31'd0, DONE},   32'd0);
        check({tag, "_wrb"},   {31'd0, W_RB},   32'd0);
        check({tag, "_we"},    {31'd0, MEM_WE}, 32'd0);
        check({tag, "_re"},    {31'd0, MEM_RE}, 32'd0);
        check({tag, "_ra_rb_wc"}, {20'd0, RA, RB, WC}, 32'd0);
        check({tag, "_wpc"},   WPC,       32'd0);
        check({tag, "_addr"},  MEM_ADDR,  32'd0);
        check({tag, "_wdata"}, MEM_WDATA, 32'd0);
    endtask

    task automatic do_load();
        @(posedge CLK); #1 load_env = 1'b1;
        @(posedge CLK); #1 load_env = 1'b0;
    endtask

    task automatic start_op(input logic sv, input logic [31:0] base);
        @(posedge CLK); #1 clr_mon = 1'b1;
        @(posedge CLK); #1 clr_mon = 1'b0;
        START = 1'b1; SAVE = sv; BASE_ADDR = base;
        @(posedge CLK); #1 START = 1'b0;
        SAVE = 1'($urandom); BASE_ADDR = $urandom;
    endtask

    // Counts cycles from acceptance to the DONE cycle; stray STARTs optional.
    task automatic wait_done(input bit pulses, output int lat, output int gaps);
        lat = 0; gaps = 0;
        while (lat < 2000) begin
            @(negedge CLK);
            lat++;
            START = pulses && (lat == 3 || lat == 10);
            if (START) begin SAVE = 1'($urandom); BASE_ADDR = $urandom; end
            if (DONE) break;
            if (!BUSY) gaps++;
        end
        START = 1'b0;
    endtask

    task automatic finish_op(input string tag);
        @(negedge CLK);
        check({tag, "_done_pulse"}, {30'd0, DONE, BUSY}, 32'd0);
        check({tag, "_done_cnt"}, done_cnt, 32'd1);
        check({tag, "_excl"}, excl_viol, 32'd0);
        check({tag, "_stall"}, stall_viol, 32'd0);
    endtask

    task automatic check_save_log(input string tag, input logic [31:0] base);
        logic [31:0] a;
        int addr_err, data_err;
        check({tag, "_wr_cnt"}, wr_cnt, NR);
        addr_err = 0; data_err = 0;
        for (int i = 0; i < NR; i++) begin
            a = base + 32'(4 * i);
            if (log_addr[i] !== a) addr_err++;
            if (log_data[i] !== exp_bank[i]) data_err++;
        end
        check({tag, "_addr_seq_errs"}, addr_err, 32'd0);
        check({tag, "_data_seq_errs"}, data_err, 32'd0);
        check({tag, "_first_data"}, log_data[0], exp_bank[0]);
        check({tag, "_last_addr"}, log_addr[NR-1], base + 32'(4 * (NR - 1)));
    endtask

    int          lat, gaps, errs, w;
    logic [31:0] base, x;

    initial begin
        n_cmp = 0; n_bad = 0;
        RESET = 1'b1; START = 1'b0; SAVE = 1'b0; BASE_ADDR = '0;
        load_env = 1'b0; clr_mon = 1'b1; wait_cfg = 0;
        for (int i = 0; i < NR; i++) bank_init[i] = '0;
        for (int i = 0; i < 256; i++) mem_init[i] = $urandom;
        do_load();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_outputs_zero("reset");
        #1 RESET = 1'b0;

        // Save, zero-wait, random bank contents.
        for (int i = 0; i < NR; i++) begin bank_init[i] = $urandom; exp_bank[i] = bank_init[i]; end
        do_load();
        start_op(1'b1, 32'h100);
        wait_done(1'b0, lat, gaps);
        check("save0_latency", lat, NR + 1);
        check("save0_busy_gaps", gaps, 0);
        check_save_log("save0", 32'h100);
        finish_op("save0");

        // Restore, zero-wait, memory pattern 0xA0000000+i at 0x200.
        for (int i = 0; i < NR; i++) begin
            mem_init[128 + i] = 32'hA000_0000 + 32'(i);
            bank_init[i] = $urandom;
        end
        do_load();
        start_op(1'b0, 32'h200);
        wait_done(1'b0, lat, gaps);
        check("rest0_latency", lat, 2 * NR + 1);
        check("rest0_wrb_cnt", wrb_cnt, NR);
        check("rest0_wrb_long", wrb_long, 0);
        errs = 0;
        for (int i = 0; i < NR; i++) if (bank[i] !== 32'hA000_0000 + 32'(i)) errs++;
        check("rest0_bank_errs", errs, 0);
        check("rest0_r15", bank[15], 32'hA000_000F);
        finish_op("rest0");

        // Save with three wait cycles per request at a random aligned base.
        for (int i = 0; i < NR; i++) begin bank_init[i] = $urandom; exp_bank[i] = bank_init[i]; end
        do_load();
        wait_cfg = 3;
        base = $urandom & 32'hFFFF_FFFC;
        start_op(1'b1, base);
        wait_done(1'b0, lat, gaps);
        check("savew_latency", lat, NR * 4 + 1);
        check("savew_busy_gaps", gaps, 0);
        check_save_log("savew", base);
        finish_op("savew");

        // Restore with a random wait count and random memory image.
        w = $urandom_range(1, 2);
        wait_cfg = w;
        for (int i = 0; i < 256; i++) mem_init[i] = $urandom;
        do_load();
        base = $urandom & 32'hFFFF_FFFC;
        start_op(1'b0, base);
        wait_done(1'b0, lat, gaps);
        check("restw_latency", lat, NR * (2 + w) + 1);
        errs = 0;
        x = '0;
        for (int i = 0; i < NR; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            if (bank[i] !== mem_init[a[9:2]]) errs++;
            x ^= mem_init[a[9:2]];
        end
        check("restw_bank_errs", errs, 0);
`ifdef REG_CTX_CHECKSUM_EN
        check("restw_checksum", CHECKSUM, x);
`endif
        finish_op("restw");
        wait_cfg = 0;

        // Stray STARTs and BASE_ADDR changes during a running save.
        for (int i = 0; i < NR; i++) begin bank_init[i] = $urandom; exp_bank[i] = bank_init[i]; end
        do_load();
        start_op(1'b1, 32'h080);
        wait_done(1'b1, lat, gaps);
        check("ign_latency", lat, NR + 1);
        check("ign_busy_gaps", gaps, 0);
        check_save_log("ign", 32'h080);
        finish_op("ign");

        // Address wrap past 0xFFFFFFFC.
        start_op(1'b1, 32'hFFFF_FFF0);
        wait_done(1'b0, lat, gaps);
        check("wrap_latency", lat, NR + 1);
        check_save_log("wrap", 32'hFFFF_FFF0);
        finish_op("wrap");

        // Reset after the fifth bank write of a restore.
        for (int i = 0; i < NR; i++) bank_init[i] = $urandom;
        for (int i = 0; i < 256; i++) mem_init[i] = $urandom;
        do_load();
        start_op(1'b0, 32'h040);
        lat = 0;
        while (wrb_cnt < 5 && lat < 500) begin @(negedge CLK); lat++; end
        check("rst_mid_reached", wrb_cnt, 5);
        RESET = 1'b1;
        @(negedge CLK);
        check_outputs_zero("rst_mid");
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_mid_wrb_cnt", wrb_cnt, 5);
        check("rst_mid_no_done", done_cnt, 0);
        errs = 0;
        for (int i = 0; i < NR; i++) begin
            exp_bank[i] = (i < 5) ? mem_init[16 + i] : bank_init[i];
            if (bank[i] !== exp_bank[i]) errs++;
        end
        check("rst_mid_bank_errs", errs, 0);
        start_op(1'b1, 32'h300);
        wait_done(1'b0, lat, gaps);
        check("rst_after_latency", lat, NR + 1);
        check_save_log("rst_after", 32'h300);
        finish_op("rst_after");

`ifdef REG_CTX_CHECKSUM_EN
        for (int i = 0; i < NR; i++) begin bank_init[i] = 32'd1 << i; exp_bank[i] = bank_init[i]; end
        do_load();
        start_op(1'b1, 32'h100);
        wait_done(1'b0, lat, gaps);
        check("cks_save", CHECKSUM, 32'h0000_FFFF);
        finish_op("cks");
        repeat (2) @(negedge CLK);
        check("cks_hold", CHECKSUM, 32'h0000_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
